// File: rtl/bias_unit_vec.sv
// Multi-column bias stage with a double-buffered (active/shadow) bias bank and one-cycle registered add.
// Optional macro BIAS_SAT_EN: saturating add plus a per-column sat_flag_out; otherwise the add wraps.
module bias_unit_vec #(
    parameter int DATA_W = 16,
    parameter int N_COLS = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       bias_load_start,
    input  logic                       bias_load_valid,
    input  logic [DATA_W-1:0]          bias_load_data,
    input  logic                       bias_swap,
    output logic                       bias_busy,
    output logic                       bias_load_done,
    output logic                       bias_shadow_ready,
    input  logic [N_COLS-1:0]          sys_valid_in,
    input  logic [N_COLS*DATA_W-1:0]   sys_data_in,
    output logic [N_COLS-1:0]          z_valid_out,
    output logic [N_COLS*DATA_W-1:0]   z_data_out
`ifdef BIAS_SAT_EN
    ,
    output logic [N_COLS-1:0]          sat_flag_out
`endif
);

    localparam int CNT_W = (N_COLS > 1) ? $clog2(N_COLS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_COLS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ready_q, ready_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] shadow_q [N_COLS];
    logic [DATA_W-1:0] active_q [N_COLS];

    logic              beat_accept;
    logic [CNT_W-1:0]  wr_idx;
    logic              last_beat;
    logic              swap_ok;

    // A start restarts the vector, so a beat arriving with it always lands in column 0.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
        beat_accept = bias_load_valid && (bias_load_start || (state_q == LOAD));
        wr_idx      = bias_load_start ? '0 : cnt_q;
        last_beat   = beat_accept && (wr_idx == LAST_IDX);
        swap_ok     = bias_swap && (state_q == IDLE) && ready_q && !bias_load_start;

        state_d = state_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        done_d  = last_beat;

        if (bias_load_start || (state_q == LOAD)) begin
            state_d = last_beat ? IDLE : LOAD;
        end

        if (bias_load_start) begin
            cnt_d   = '0;
            ready_d = 1'b0;
        end
        if (beat_accept) begin
            cnt_d = last_beat ? '0 : wr_idx + CNT_W'(1);
        end

        if (last_beat) begin
            ready_d = 1'b1;
        end
        if (swap_ok) begin
            ready_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    // NOTE: the bias banks are tiny register files and must read as zero after reset, so they are reset explicitly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_COLS; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            if (beat_accept) begin
                shadow_q[wr_idx] <= bias_load_data;
            end
            if (swap_ok) begin
                active_q <= shadow_q;
            end
        end
    end

    assign bias_busy         = (state_q == LOAD);
    assign bias_load_done    = done_q;
    assign bias_shadow_ready = ready_q;

    // Per-column datapath; reads the active bank before any swap on the same edge takes effect.
    for (genvar c = 0; c < N_COLS; c++) begin : g_col
        logic [DATA_W-1:0] d_in;
        logic [DATA_W-1:0] b_in;
        logic [DATA_W-1:0] result;
        logic              zv_q;
        logic [DATA_W-1:0] zd_q;

        assign d_in = sys_data_in[c*DATA_W +: DATA_W];
        assign b_in = active_q[c];

`ifdef BIAS_SAT_EN
        logic [DATA_W:0] sum;
        logic            ovf;
        logic            sat_q;

        assign sum    = {d_in[DATA_W-1], d_in} + {b_in[DATA_W-1], b_in};
        assign ovf    = sum[DATA_W] ^ sum[DATA_W-1];
        assign result = !ovf ? sum[DATA_W-1:0]
                      : (sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}}
                                     : {1'b0, {(DATA_W-1){1'b1}}});

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sat_q <= 1'b0;
            end else begin
                sat_q <= sys_valid_in[c] && ovf;
            end
        end
        assign sat_flag_out[c] = sat_q;
`else
        assign result = d_in + b_in;
`endif

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                zv_q <= 1'b0;
                zd_q <= '0;
            end else begin
                zv_q <= sys_valid_in[c];
                zd_q <= sys_valid_in[c] ? result : '0;
            end
        end

        assign z_valid_out[c]                = zv_q;
        assign z_data_out[c*DATA_W +: DATA_W] = zd_q;
    end

endmodule

// File: tb/tb_bias_unit_vec.sv
// Self-checking bench for bias_unit_vec: directed scenarios plus random traffic against a behavioural model.
// Works with or without BIAS_SAT_EN defined.
module tb_bias_unit_vec;

    localparam int DW = 16;
    localparam int N  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              bias_load_start;
    logic              bias_load_valid;
    logic [DW-1:0]     bias_load_data;
    logic              bias_swap;
    logic              bias_busy;
    logic              bias_load_done;
    logic              bias_shadow_ready;
    logic [N-1:0]      sys_valid_in;
    logic [N*DW-1:0]   sys_data_in;
    logic [N-1:0]      z_valid_out;
    logic [N*DW-1:0]   z_data_out;
`ifdef BIAS_SAT_EN
    logic [N-1:0]      sat_flag_out;
`endif

    bias_unit_vec #(.DATA_W(DW), .N_COLS(N)) dut (
        .clk               (clk),
        .rst               (rst),
        .bias_load_start   (bias_load_start),
        .bias_load_valid   (bias_load_valid),
        .bias_load_data    (bias_load_data),
        .bias_swap         (bias_swap),
        .bias_busy         (bias_busy),
        .bias_load_done    (bias_load_done),
        .bias_shadow_ready (bias_shadow_ready),
        .sys_valid_in      (sys_valid_in),
        .sys_data_in       (sys_data_in),
        .z_valid_out       (z_valid_out),
        .z_data_out        (z_data_out)
`ifdef BIAS_SAT_EN
        ,
        .sat_flag_out      (sat_flag_out)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_count = 0;

    // Behavioural model: the bias banks as plain arrays, the loader as a flag plus beat index.
    logic [DW-1:0]   m_active [N];
    logic [DW-1:0]   m_shadow [N];
    bit              m_loading;
    bit              m_ready;
    bit              m_done;
    int              m_cnt;
    logic [N-1:0]    e_zv;
    logic [N*DW-1:0] e_zd;
    logic [N-1:0]    e_sat;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_active[i] = '0;
            m_shadow[i] = '0;
        end
        m_loading = 0;
        m_ready   = 0;
        m_done    = 0;
        m_cnt     = 0;
        e_zv      = '0;
        e_zd      = '0;
        e_sat     = '0;
    endtask

    function automatic longint sval(input logic [DW-1:0] x);
        longint v;
        v = $signed(x);
        return v;
    endfunction

    function automatic logic [N*DW-1:0] rep(input logic [DW-1:0] v);
        return {N{v}};
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".z_valid"}, 64'(z_valid_out), 64'(e_zv));
        check({tag, ".z_data"}, 64'(z_data_out), 64'(e_zd));
        check({tag, ".busy"}, 64'(bias_busy), 64'(m_loading));
        check({tag, ".done"}, 64'(bias_load_done), 64'(m_done));
        check({tag, ".ready"}, 64'(bias_shadow_ready), 64'(m_ready));
`ifdef BIAS_SAT_EN
        check({tag, ".sat"}, 64'(sat_flag_out), 64'(e_sat));
`endif
    endtask

    // One clock: drive inputs, predict the post-edge outputs, advance the model, then compare.
    task automatic step(input string tag, input bit st, input bit lv, input logic [DW-1:0] ld,
                        input bit sw, input logic [N-1:0] sv, input logic [N*DW-1:0] sd);
        bit     swap_ok;
        longint lo, hi, s;
        lo = -(longint'(1) << (DW - 1));
        hi = (longint'(1) << (DW - 1)) - 1;
        bias_load_start = st;
        bias_load_valid = lv;
        bias_load_data  = ld;
        bias_swap       = sw;
        sys_valid_in    = sv;
        sys_data_in     = sd;

        for (int c = 0; c < N; c++) begin
            s = sval(sd[c*DW +: DW]) + sval(m_active[c]);
            e_sat[c] = sv[c] && (s > hi || s < lo);
`ifdef BIAS_SAT_EN
            if (s > hi) s = hi;
            if (s < lo) s = lo;
`endif
            e_zv[c] = sv[c];
            e_zd[c*DW +: DW] = sv[c] ? s[DW-1:0] : '0;
        end

        swap_ok = sw && !m_loading && m_ready && !st;
        m_done  = 0;
        if (st) begin
            m_loading = 1;
            m_cnt     = 0;
            m_ready   = 0;
        end
        if (m_loading && lv) begin
            m_shadow[m_cnt] = ld;
            m_cnt++;
            if (m_cnt == N) begin
                m_loading = 0;
                m_ready   = 1;
                m_done    = 1;
                m_cnt     = 0;
            end
        end
        if (swap_ok) begin
            m_active = m_shadow;
            m_ready  = 0;
        end

        @(posedge clk);
        #1;
        check_all(tag);
        if (bias_load_done) done_count++;
    endtask

    task automatic load_vec(input string tag, input logic [DW-1:0] b0, input logic [DW-1:0] b1,
                            input logic [DW-1:0] b2, input logic [DW-1:0] b3,
                            input logic [N-1:0] sv, input logic [N*DW-1:0] sd);
        step(tag, 1, 0, '0, 0, sv, sd);
        step(tag, 0, 1, b0, 0, sv, sd);
        step(tag, 0, 1, b1, 0, sv, sd);
        step(tag, 0, 1, b2, 0, sv, sd);
        step(tag, 0, 1, b3, 0, sv, sd);
    endtask

    initial begin
        rst = 1'b1;
        bias_load_start = 0;
        bias_load_valid = 0;
        bias_load_data  = '0;
        bias_swap       = 0;
        sys_valid_in    = '0;
        sys_data_in     = '0;
        model_reset();
        #12;
        check_all("reset");
        rst = 1'b0;

        // Basic load, swap and biased output.
        load_vec("t1_load", 16'd10, 16'd20, 16'd30, 16'd40, '0, '0);
        step("t1_idle", 0, 0, '0, 0, '0, '0);
        check("t1_ready_high", 64'(bias_shadow_ready), 64'd1);
        step("t1_swap", 0, 0, '0, 1, '0, '0);
        check("t1_ready_cleared", 64'(bias_shadow_ready), 64'd0);
        step("t1_data", 0, 0, '0, 0, 4'hF, rep(16'd100));
        check("t1_z_value", 64'(z_data_out), {16'd140, 16'd130, 16'd120, 16'd110});
        check("t1_done_once", 64'(done_count), 64'd1);

        // Ping-pong: stream data while loading the next vector.
        load_vec("t2_pre", 16'd1, 16'd1, 16'd1, 16'd1, '0, '0);
        step("t2_preswap", 0, 0, '0, 1, '0, '0);
        load_vec("t2_load", 16'd5, 16'd5, 16'd5, 16'd5, 4'hF, rep(16'd7));
        check("t2_during_load", 64'(z_data_out), 64'(rep(16'd8)));
        step("t2_swapcyc", 0, 0, '0, 1, 4'hF, rep(16'd7));
        check("t2_old_bias_on_swap", 64'(z_data_out), 64'(rep(16'd8)));
        step("t2_after", 0, 0, '0, 0, 4'hF, rep(16'd7));
        check("t2_new_bias", 64'(z_data_out), 64'(rep(16'd12)));

        // Illegal swaps: no ready shadow, mid-load, on the final beat, and together with start.
        step("t3_noready", 0, 0, '0, 1, 4'hF, rep(16'd7));
        step("t3_noready_chk", 0, 0, '0, 0, 4'hF, rep(16'd7));
        check("t3_unchanged", 64'(z_data_out), 64'(rep(16'd12)));
        step("t3_start", 1, 0, '0, 0, 4'hF, rep(16'd7));
        step("t3_b0", 0, 1, 16'd9, 0, 4'hF, rep(16'd7));
        step("t3_b1", 0, 1, 16'd9, 0, 4'hF, rep(16'd7));
        step("t3_midswap", 0, 0, '0, 1, 4'hF, rep(16'd7));
        step("t3_b2", 0, 1, 16'd9, 0, 4'hF, rep(16'd7));
        step("t3_b3swap", 0, 1, 16'd9, 1, 4'hF, rep(16'd7));
        check("t3_still_old", 64'(z_data_out), 64'(rep(16'd12)));
        step("t3_startswap", 1, 0, '0, 1, 4'hF, rep(16'd7));
        step("t3_startswap_chk", 0, 0, '0, 0, 4'hF, rep(16'd7));
        check("t3_start_wins", 64'(z_data_out), 64'(rep(16'd12)));
        step("t3_r0", 0, 1, 16'd9, 0, '0, '0);
        step("t3_r1", 0, 1, 16'd9, 0, '0, '0);
        step("t3_r2", 0, 1, 16'd9, 0, '0, '0);
        step("t3_r3", 0, 1, 16'd9, 0, '0, '0);
        step("t3_legal", 0, 0, '0, 1, '0, '0);
        step("t3_legal_chk", 0, 0, '0, 0, 4'hF, rep(16'd7));
        check("t3_legal_works", 64'(z_data_out), 64'(rep(16'd16)));

        // Staggered column valids.
        step("t4_v1", 0, 0, '0, 0, 4'b0001, rep(16'd50));
        step("t4_v3", 0, 0, '0, 0, 4'b0011, rep(16'd50));
        step("t4_v7", 0, 0, '0, 0, 4'b0111, rep(16'd50));
        check("t4_partial", 64'(z_data_out), {16'd0, 16'd59, 16'd59, 16'd59});
        step("t4_vF", 0, 0, '0, 0, 4'b1111, rep(16'd50));
        step("t4_v0", 0, 0, '0, 0, 4'b0000, rep(16'd50));

        // Overflow in both directions.
        load_vec("t5_load", 16'h0200, 16'hFE00, 16'h0000, 16'h0000, '0, '0);
        step("t5_swap", 0, 0, '0, 1, '0, '0);
        step("t5_data", 0, 0, '0, 0, 4'hF, {16'h0000, 16'h0000, 16'h8100, 16'h7F00});
`ifdef BIAS_SAT_EN
        check("t5_clamp", 64'(z_data_out), {16'h0000, 16'h0000, 16'h8000, 16'h7FFF});
        check("t5_sat_flag", 64'(sat_flag_out), 64'h3);
`else
        check("t5_wrap", 64'(z_data_out), {16'h0000, 16'h0000, 16'h7F00, 16'h8100});
`endif

        // Asynchronous reset in the middle of a load.
        step("t6_start", 1, 0, '0, 0, 4'hF, rep(16'd3));
        step("t6_b0", 0, 1, 16'd77, 0, 4'hF, rep(16'd3));
        step("t6_b1", 0, 1, 16'd77, 0, 4'hF, rep(16'd3));
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("t6_busy_async", 64'(bias_busy), 64'd0);
        check("t6_ready_async", 64'(bias_shadow_ready), 64'd0);
        check("t6_zv_async", 64'(z_valid_out), 64'd0);
        check("t6_zd_async", 64'(z_data_out), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        step("t6_swap_ignored", 0, 0, '0, 1, '0, '0);
        step("t6_data", 0, 0, '0, 0, 4'hF, rep(16'd123));
        check("t6_zero_bias", 64'(z_data_out), 64'(rep(16'd123)));

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step("rand",
                 $urandom_range(0, 11) == 0,
                 $urandom_range(0, 2) != 0,
                 DW'($urandom),
                 $urandom_range(0, 5) == 0,
                 N'($urandom),
                 {$urandom, $urandom});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
